// File: rtl/mem_arb.sv
// Two-master memory arbiter: fetch (IF) and load/store (LSU) ports share one
// memory port, one transaction outstanding, with a bounded LSU priority streak.
module mem_arb #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned LS_STREAK_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,

    input  logic            ls_req_i,
    input  logic            ls_we_i,
    input  logic [XLEN-1:0] ls_addr_i,
    input  logic [XLEN-1:0] ls_wdata_i,
    input  logic [7:0]      ls_wmask_i,
    output logic            ls_gnt_o,
    output logic            ls_rvalid_o,
    output logic [XLEN-1:0] ls_rdata_o,

    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [7:0]      mem_wmask_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,

    output logic            err_o
);

    localparam int unsigned SW = $clog2(LS_STREAK_MAX + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP
    } state_e;

    state_e          state_q;
    logic [SW-1:0]   streak_q;
    logic [SW-1:0]   streak_nxt;
    logic            owner_ls_q;
    logic            if_win;
    logic            ls_win;

    // Arbitration: grants are combinational and only offered in IDLE.
    always_comb begin
        if_win     = 1'b0;
        ls_win     = 1'b0;
        streak_nxt = streak_q;
        if (state_q == ST_IDLE && !rst) begin
            if (if_req_i && ls_req_i) begin
                if (streak_q < SW'(LS_STREAK_MAX)) begin
                    ls_win     = 1'b1;
                    streak_nxt = streak_q + SW'(1);
                end else begin
                    if_win     = 1'b1;
                    streak_nxt = '0;
                end
            end else if (ls_req_i) begin
                ls_win     = 1'b1;
                streak_nxt = '0;
            end else if (if_req_i) begin
                if_win     = 1'b1;
                streak_nxt = '0;
            end
        end
    end

    assign if_gnt_o = if_win;
    assign ls_gnt_o = ls_win;

    // Transaction FSM with latched command and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            streak_q    <= '0;
            owner_ls_q  <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wmask_o <= '0;
            if_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            ls_rvalid_o <= 1'b0;
            ls_rdata_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            if_rvalid_o <= 1'b0;
            ls_rvalid_o <= 1'b0;

            // Strobes arriving in the wrong phase are flagged and dropped.
            if ((mem_rvalid_i && state_q != ST_RSP) ||
                (mem_gnt_i && state_q != ST_REQ)) begin
                err_o <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (if_win || ls_win) begin
                        streak_q   <= streak_nxt;
                        owner_ls_q <= ls_win;
                        mem_req_o  <= 1'b1;
                        state_q    <= ST_REQ;
                        if (ls_win) begin
                            mem_we_o    <= ls_we_i;
                            mem_addr_o  <= {ls_addr_i[XLEN-1:3], 3'b000};
                            mem_wdata_o <= ls_wdata_i;
                            mem_wmask_o <= ls_we_i ? ls_wmask_i : 8'h00;
                        end else begin
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= {if_addr_i[XLEN-1:3], 3'b000};
                            mem_wdata_o <= '0;
                            mem_wmask_o <= 8'h00;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (mem_rvalid_i) begin
                        state_q <= ST_IDLE;
                        if (owner_ls_q) begin
                            ls_rvalid_o <= 1'b1;
                            ls_rdata_o  <= mem_we_o ? '0 : mem_rdata_i;
                        end else begin
                            if_rvalid_o <= 1'b1;
                            if_rdata_o  <= mem_rdata_i;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the arbiter kept in the monitor.
module tb_mem_arb;

    localparam int XLEN   = 64;
    localparam int STREAK = 3;

    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_RSP  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req_i;
    logic [63:0]     if_addr_i;
    logic            if_gnt_o, if_rvalid_o;
    logic [63:0]     if_rdata_o;
    logic            ls_req_i, ls_we_i;
    logic [63:0]     ls_addr_i, ls_wdata_i;
    logic [7:0]      ls_wmask_i;
    logic            ls_gnt_o, ls_rvalid_o;
    logic [63:0]     ls_rdata_o;
    logic            mem_req_o, mem_we_o;
    logic [63:0]     mem_addr_o, mem_wdata_o;
    logic [7:0]      mem_wmask_o;
    logic            mem_gnt_i, mem_rvalid_i;
    logic [63:0]     mem_rdata_i;
    logic            err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arb #(.XLEN(XLEN), .LS_STREAK_MAX(STREAK)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .err_o(err_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory responder ----------------
    bit          mem_auto = 1'b1;
    bit          rand_lat = 1'b0;
    bit          rdata_rand = 1'b0;
    int          gnt_wait = 0;
    logic [63:0] rdata_val = '0;
    bit          man_gnt = 1'b0;
    bit          man_rvalid = 1'b0;
    int          req_cnt = 0, rsp_cnt = 0, g_wait = 0, r_wait = 0;
    bit          rsp_pend = 1'b0;

    initial begin
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i = rdata_val;
            if (!mem_auto) begin
                mem_gnt_i = man_gnt;
                mem_rvalid_i = man_rvalid;
                rsp_pend = 1'b0;
                req_cnt = 0;
            end else if (rst) begin
                rsp_pend = 1'b0;
                req_cnt = 0;
            end else if (mem_req_o) begin
                if (req_cnt >= (rand_lat ? g_wait : gnt_wait)) begin
                    mem_gnt_i = 1'b1;
                    req_cnt = 0;
                    rsp_pend = 1'b1;
                    rsp_cnt = 0;
                    r_wait = rand_lat ? int'($urandom_range(0, 3)) : 0;
                    g_wait = int'($urandom_range(0, 3));
                end else begin
                    req_cnt++;
                end
            end else if (rsp_pend) begin
                if (rsp_cnt >= r_wait) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i = rdata_rand ? {$urandom, $urandom} : rdata_val;
                    rsp_pend = 1'b0;
                end else begin
                    rsp_cnt++;
                end
            end
        end
    end

    // ---------------- reference model / monitor ----------------
    int          m_state = M_IDLE;
    int          m_streak = 0;
    bit          m_err = 1'b0;
    int          exp_rv = 0;
    logic [63:0] exp_data = '0;
    logic [63:0] m_if_data = '0, m_ls_data = '0;
    bit          c_ls = 1'b0, c_we = 1'b0;
    logic [63:0] c_addr = '0, c_wdata = '0;
    logic [7:0]  c_mask = '0;
    bit          prev_rst = 1'b0;
    bit          gnt_log[$];
    int          n_gnt = 0, n_if_rv = 0, n_ls_rv = 0;

    always @(negedge clk) begin
        bit e_if, e_ls;
        e_if = 1'b0;
        e_ls = 1'b0;
        if (rst) begin
            check("rst_if_gnt", 64'(if_gnt_o), 64'(0));
            check("rst_ls_gnt", 64'(ls_gnt_o), 64'(0));
            if (prev_rst) begin
                check("rst_mem_req", 64'(mem_req_o), 64'(0));
                check("rst_err", 64'(err_o), 64'(0));
                check("rst_if_rv", 64'(if_rvalid_o), 64'(0));
                check("rst_ls_rv", 64'(ls_rvalid_o), 64'(0));
                check("rst_if_rdata", if_rdata_o, 64'(0));
                check("rst_ls_rdata", ls_rdata_o, 64'(0));
                check("rst_mem_addr", mem_addr_o, 64'(0));
            end
            m_state = M_IDLE;
            m_streak = 0;
            m_err = 1'b0;
            exp_rv = 0;
            m_if_data = '0;
            m_ls_data = '0;
        end else begin
            if (exp_rv == 1) m_if_data = exp_data;
            if (exp_rv == 2) m_ls_data = exp_data;
            check("if_rvalid", 64'(if_rvalid_o), 64'(exp_rv == 1));
            check("ls_rvalid", 64'(ls_rvalid_o), 64'(exp_rv == 2));
            check("if_rdata", if_rdata_o, m_if_data);
            check("ls_rdata", ls_rdata_o, m_ls_data);
            if (if_rvalid_o) n_if_rv++;
            if (ls_rvalid_o) n_ls_rv++;
            check("err", 64'(err_o), 64'(m_err));
            check("mem_req", 64'(mem_req_o), 64'(m_state == M_REQ));
            if (m_state == M_REQ) begin
                check("mem_we", 64'(mem_we_o), 64'(c_we));
                check("mem_addr", mem_addr_o, c_addr);
                check("mem_wdata", mem_wdata_o, c_wdata);
                check("mem_wmask", 64'(mem_wmask_o), 64'(c_mask));
            end
            exp_rv = 0;

            if (m_state == M_IDLE) begin
                if (if_req_i && ls_req_i) begin
                    if (m_streak < STREAK) e_ls = 1'b1;
                    else e_if = 1'b1;
                end else begin
                    e_if = if_req_i;
                    e_ls = ls_req_i;
                end
            end
            check("if_gnt", 64'(if_gnt_o), 64'(e_if));
            check("ls_gnt", 64'(ls_gnt_o), 64'(e_ls));

            if ((mem_rvalid_i && m_state != M_RSP) || (mem_gnt_i && m_state != M_REQ))
                m_err = 1'b1;

            if (m_state == M_IDLE && (e_if || e_ls)) begin
                m_streak = (if_req_i && ls_req_i && e_ls) ? m_streak + 1 : 0;
                c_ls = e_ls;
                c_we = e_ls && ls_we_i;
                c_addr = (e_ls ? ls_addr_i : if_addr_i) & ~64'h7;
                c_wdata = e_ls ? ls_wdata_i : 64'h0;
                c_mask = c_we ? ls_wmask_i : 8'h00;
                gnt_log.push_back(e_ls);
                n_gnt++;
                m_state = M_REQ;
            end else if (m_state == M_REQ) begin
                if (mem_gnt_i) m_state = M_RSP;
            end else if (m_state == M_RSP) begin
                if (mem_rvalid_i) begin
                    exp_rv = c_ls ? 2 : 1;
                    exp_data = c_we ? 64'h0 : mem_rdata_i;
                    m_state = M_IDLE;
                end
            end
        end
        prev_rst = rst;
    end

    // ---------------- stimulus ----------------
    initial begin
        int base_if, base_ls, base_gnt;
        bit if_g, ls_g;

        rst = 1'b1;
        if_req_i = 1'b1;
        if_addr_i = 64'h100;
        ls_req_i = 1'b1;
        ls_we_i = 1'b0;
        ls_addr_i = 64'h208;
        ls_wdata_i = '0;
        ls_wmask_i = '0;

        // Reset with both requests pending; LSU must win the first free cycle.
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("first_ls_gnt", 64'(ls_gnt_o), 64'(1));
        check("first_if_gnt", 64'(if_gnt_o), 64'(0));
        tick();
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        repeat (4) tick();

        // Fetch at minimum latency.
        rdata_val = 64'h1122_3344_5566_7788;
        if_req_i = 1'b1;
        if_addr_i = 64'h8000_0004;
        @(negedge clk);
        check("if_gnt_n", 64'(if_gnt_o), 64'(1));
        tick();
        if_req_i = 1'b0;
        @(negedge clk);
        check("if_mem_req_n1", 64'(mem_req_o), 64'(1));
        check("if_mem_addr", mem_addr_o, 64'h8000_0000);
        check("if_mem_wmask", 64'(mem_wmask_o), 64'(0));
        tick();
        tick();
        @(negedge clk);
        check("if_rvalid_n3", 64'(if_rvalid_o), 64'(1));
        check("if_rdata_n3", if_rdata_o, 64'h1122_3344_5566_7788);
        tick();
        @(negedge clk);
        check("if_rvalid_n4", 64'(if_rvalid_o), 64'(0));

        // LSU store: aligned address, mask kept, zero response data.
        tick();
        ls_req_i = 1'b1;
        ls_we_i = 1'b1;
        ls_addr_i = 64'h8000_0013;
        ls_wdata_i = 64'hAB;
        ls_wmask_i = 8'h08;
        @(negedge clk);
        check("st_gnt", 64'(ls_gnt_o), 64'(1));
        tick();
        ls_req_i = 1'b0;
        @(negedge clk);
        check("st_mem_we", 64'(mem_we_o), 64'(1));
        check("st_mem_addr", mem_addr_o, 64'h8000_0010);
        check("st_mem_wmask", 64'(mem_wmask_o), 64'h08);
        check("st_mem_wdata", mem_wdata_o, 64'hAB);
        tick();
        tick();
        @(negedge clk);
        check("st_rvalid", 64'(ls_rvalid_o), 64'(1));
        check("st_rdata", ls_rdata_o, 64'h0);
        check("st_if_rdata_kept", if_rdata_o, 64'h1122_3344_5566_7788);
        ls_we_i = 1'b0;
        repeat (3) tick();

        // Both held continuously: LSU streak bounded to three.
        gnt_log.delete();
        if_req_i = 1'b1;
        ls_req_i = 1'b1;
        if_addr_i = 64'h40;
        ls_addr_i = 64'h80;
        for (int k = 0; k < 60 && gnt_log.size() < 8; k++) @(negedge clk);
        check("order_count", 64'(gnt_log.size() >= 8), 64'(1));
        tick();
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        for (int i = 0; i < 8 && i < gnt_log.size(); i++)
            check($sformatf("order_%0d", i), 64'(gnt_log[i]), 64'((i % 4) != 3));
        repeat (5) tick();

        // Memory stalls grant for five cycles while the fetch request toggles.
        gnt_wait = 5;
        base_if = n_if_rv;
        if_req_i = 1'b1;
        if_addr_i = 64'h0000_1234_5678_9ABF;
        @(negedge clk);
        check("stall_gnt", 64'(if_gnt_o), 64'(1));
        for (int k = 0; k < 5; k++) begin
            tick();
            if_req_i = ~if_req_i;
            @(negedge clk);
            check("stall_mem_req", 64'(mem_req_o), 64'(1));
            check("stall_mem_addr", mem_addr_o, 64'h0000_1234_5678_9AB8);
            check("stall_no_gnt", 64'({if_gnt_o, ls_gnt_o}), 64'(0));
        end
        tick();
        if_req_i = 1'b0;
        repeat (3) tick();
        gnt_wait = 0;
        @(negedge clk);
        check("stall_done", 64'(n_if_rv - base_if), 64'(1));

        // Stray rvalid in IDLE sets a sticky error.
        mem_auto = 1'b0;
        tick();
        man_rvalid = 1'b1;
        tick();
        man_rvalid = 1'b0;
        @(negedge clk);
        check("err_set", 64'(err_o), 64'(1));
        repeat (3) tick();
        @(negedge clk);
        check("err_sticky", 64'(err_o), 64'(1));

        // Reset during RSP, coincident with rvalid: transaction abandoned.
        base_ls = n_ls_rv;
        tick();
        ls_req_i = 1'b1;
        ls_addr_i = 64'h300;
        @(negedge clk);
        check("rstrsp_gnt", 64'(ls_gnt_o), 64'(1));
        tick();
        ls_req_i = 1'b0;
        man_gnt = 1'b1;
        tick();
        man_gnt = 1'b0;
        man_rvalid = 1'b1;
        rst = 1'b1;
        tick();
        man_rvalid = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rstrsp_no_rv", 64'(n_ls_rv - base_ls), 64'(0));
        check("rstrsp_err", 64'(err_o), 64'(0));
        mem_auto = 1'b1;

        // Randomized traffic with random memory latency.
        rand_lat = 1'b1;
        rdata_rand = 1'b1;
        base_gnt = n_gnt;
        if_g = 1'b0;
        ls_g = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (!if_req_i || if_g) begin
                if_req_i = ($urandom_range(0, 2) != 0);
                if_addr_i = {$urandom, $urandom};
            end
            if (!ls_req_i || ls_g) begin
                ls_req_i = ($urandom_range(0, 2) != 0);
                ls_we_i = $urandom_range(0, 1) != 0;
                ls_addr_i = {$urandom, $urandom};
                ls_wdata_i = {$urandom, $urandom};
                ls_wmask_i = 8'($urandom);
            end
            @(negedge clk);
            if_g = if_gnt_o;
            ls_g = ls_gnt_o;
        end
        tick();
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("rand_progress", 64'((n_gnt - base_gnt) > 100), 64'(1));
        check("rand_err", 64'(err_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, datapath and address width.
REQ-002 The block SHALL have parameter LS_STREAK_MAX, default 3, max consecutive contended LSU grants before a fetch is forced.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port if_req_i, input, 1, fetch read request; held with if_addr_i until granted.
REQ-006 The block SHALL have port if_addr_i, input, XLEN, fetch byte address.
REQ-007 The block SHALL have ports if_gnt_o (output, 1, request accepted this cycle), if_rvalid_o (output, 1, one-cycle response strobe) and if_rdata_o (output, XLEN, response data).
REQ-008 The block SHALL have ports ls_req_i (input, 1), ls_we_i (input, 1, 1=store), ls_addr_i (input, XLEN), ls_wdata_i (input, XLEN) and ls_wmask_i (input, 8, byte enables); all held until granted.
REQ-009 The block SHALL have ports ls_gnt_o (output, 1), ls_rvalid_o (output, 1, load data or store ack) and ls_rdata_o (output, XLEN).
REQ-010 The block SHALL have memory-side outputs mem_req_o (1), mem_we_o (1), mem_addr_o (XLEN), mem_wdata_o (XLEN) and mem_wmask_o (8).
REQ-011 The block SHALL have memory-side inputs mem_gnt_i (1), mem_rvalid_i (1) and mem_rdata_i (XLEN).
REQ-012 The block SHALL have port err_o, output, 1, sticky protocol-error flag.

Function
REQ-013 The FSM SHALL have three states: IDLE, REQ (mem_req_o high, awaiting mem_gnt_i) and RSP (awaiting mem_rvalid_i); at most one transaction is outstanding.
REQ-014 In IDLE, if_gnt_o/ls_gnt_o SHALL be combinational, high only for the arbitration winner; elsewhere both are 0.
REQ-015 Arbitration: only IF requests -> IF wins, streak=0; only LSU requests -> LSU wins, streak=0; both request and streak<LS_STREAK_MAX -> LSU wins, streak+1; both request and streak==LS_STREAK_MAX -> IF wins, streak=0.
REQ-016 On a grant edge, the block SHALL latch owner, we (0 for IF), addr&~7, wdata (0 for IF) and wmask (0 for IF or LSU load), then enter REQ.
REQ-017 mem_* command outputs SHALL be driven from the latched registers and stay stable throughout REQ; in IDLE/RSP, mem_req_o=0.
REQ-018 In REQ, mem_gnt_i high SHALL move the FSM to RSP on that edge.
REQ-019 In RSP, mem_rvalid_i high SHALL, on that edge, register mem_rdata_i (0 for stores) into the owner's rdata, assert the owner's rvalid for exactly the next cycle, and return to IDLE.
REQ-020 A new grant SHALL be possible in the same cycle that rvalid_o is high (IDLE); the non-owner's rdata is unchanged.
REQ-021 Minimum latency SHALL be: grant cycle N, mem_req_o cycle N+1, mem_rvalid_i earliest N+2, rvalid_o N+3.
REQ-022 mem_rvalid_i outside RSP, or mem_gnt_i outside REQ, SHALL set err_o to 1 and be otherwise ignored; err_o clears only on reset.
REQ-023 Requests arriving in REQ/RSP SHALL NOT be granted until IDLE.

Reset
REQ-024 While rst is high, the FSM SHALL go to IDLE, streak=0, owner=IF, and all outputs including err_o, rdata and latched command fields SHALL be 0.
REQ-025 Reset asserted in REQ or RSP SHALL abandon the transaction with no rvalid_o pulse, including for a mem_rvalid_i coincident with rst.
REQ-026 The first arbitration SHALL occur in the first cycle with rst low.

Verification
REQ-027 rst high 2 cycles with both requests high -> no gnt_o, mem_req_o=0, err_o=0; cycle after release ls_gnt_o=1.
REQ-028 IF read 0x8000_0004, mem_gnt_i immediate, mem_rvalid_i next cycle with 0x1122_3344_5566_7788 -> mem_addr_o=0x8000_0000, mem_wmask_o=0, if_rvalid_o one cycle with that data at N+3.
REQ-029 LSU store 0x8000_0013, wdata 0xAB, mask 0x08 -> mem_we_o=1, mem_addr_o=0x8000_0010, mem_wmask_o=0x08; ls_rvalid_o pulse with ls_rdata_o=0.
REQ-030 Both requests held continuously, memory responding at minimum latency -> grant order L,L,L,I,L,L,L,I.
REQ-031 mem_gnt_i low 5 cycles in REQ with if_req_i toggling -> mem_* stable, no gnt_o; then normal completion.
REQ-032 mem_rvalid_i in IDLE -> err_o=1 and stays 1; no rvalid_o; rst during RSP -> no rvalid_o, err_o=0.
